// File: rtl/mlp_train_sequencer_pkg.sv
// Shared types for the MLP training datapath: sequencer state encoding and
// the perceptron activation helper.
package Common;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        LOAD   = 3'd2,
        UPDATE = 3'd3,
        DONE   = 3'd4
    } seq_state_t;

    // Step activation used by the perceptrons: fires on a non-negative net sum.
    function automatic logic act_func(input logic signed [15:0] net);
        return !net[15];
    endfunction

endpackage

// File: rtl/mlp_train_sequencer.sv
// Training sequencer for a small MLP: walks the sample store once per epoch,
// holds each sample long enough for the forward/backward chain to settle, then
// issues a one-cycle weight-update pulse. Optionally re-initialises weights first.
module mlp_train_sequencer
    import Common::*;
#(
    parameter int NUM_SAMPLES   = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int EPOCH_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                reinit,
    input  logic [EPOCH_W-1:0]  num_epochs,
    input  logic                abort,
    output logic                weight_init,
    output logic [((NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1)-1:0] sample_idx,
    output logic                sample_valid,
    output logic                training,
    output logic [EPOCH_W-1:0]  epoch_count,
    output logic                busy,
    output logic                done
);

    localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_SAMPLES - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    seq_state_t         state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [EPOCH_W-1:0] target_q, target_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [EPOCH_W-1:0] epoch_inc;

    assign epoch_inc = epoch_q + 1'b1;

    // Next-state and counter updates; abort overrides every transition out of a busy state.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        epoch_d  = epoch_q;
        target_d = target_q;
        settle_d = settle_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    target_d = num_epochs;
                    idx_d    = '0;
                    epoch_d  = '0;
                    settle_d = '0;
                    if (num_epochs == '0) begin
                        state_d = DONE;
                    end else if (reinit) begin
                        state_d = INIT;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            INIT: begin
                idx_d    = '0;
                epoch_d  = '0;
                settle_d = '0;
                state_d  = LOAD;
            end
            LOAD: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = UPDATE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            UPDATE: begin
                settle_d = '0;
                if (idx_q != IDX_LAST) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end else begin
                    idx_d   = '0;
                    epoch_d = epoch_inc;
                    if (epoch_inc == target_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            idx_d    = idx_q;
            epoch_d  = epoch_q;
            settle_d = '0;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            epoch_q  <= '0;
            target_q <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            epoch_q  <= epoch_d;
            target_q <= target_d;
            settle_q <= settle_d;
        end
    end

    // Outputs decoded purely from registered state, so the pulses are glitch-free and exclusive.
    always_comb begin
        weight_init  = (state_q == INIT);
        sample_valid = (state_q == LOAD) || (state_q == UPDATE);
        training     = (state_q == UPDATE);
        done         = (state_q == DONE);
        busy         = (state_q != IDLE);
        sample_idx   = idx_q;
        epoch_count  = epoch_q;
    end

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Self-checking bench for mlp_train_sequencer (NUM_SAMPLES=4, SETTLE_CYCLES=2,
// EPOCH_W=3 so the all-ones epoch target is reachable in a short run).
module tb_mlp_train_sequencer;

    localparam int NS = 4;
    localparam int EW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          reinit;
    logic [EW-1:0] num_epochs;
    logic          abort;
    logic          weight_init;
    logic [1:0]    sample_idx;
    logic          sample_valid;
    logic          training;
    logic [EW-1:0] epoch_count;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int exp_idx_q[$];

    typedef struct {
        logic   reinit;
        logic   abort_with_start;
        int     epochs;
        int     poke_a;
        int     poke_b;
        int     exp_latency;
        int     exp_trains;
        int     exp_winits;
        int     exp_final_epoch;
    } run_vec_t;

    run_vec_t vecs[7];

    always #5 clk = ~clk;

    mlp_train_sequencer #(
        .NUM_SAMPLES  (NS),
        .SETTLE_CYCLES(2),
        .EPOCH_W      (EW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .reinit      (reinit),
        .num_epochs  (num_epochs),
        .abort       (abort),
        .weight_init (weight_init),
        .sample_idx  (sample_idx),
        .sample_valid(sample_valid),
        .training    (training),
        .epoch_count (epoch_count),
        .busy        (busy),
        .done        (done)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drives a one-cycle start and queues the sample indices the run should update on.
    // Returns during cycle 1 (the cycle after the start-sampling edge).
    task automatic applyStimulus(input logic r, input logic ab, input int ne);
        @(negedge clk);
        start      = 1'b1;
        reinit     = r;
        abort      = ab;
        num_epochs = EW'(ne);
        for (int e = 0; e < ne; e++) begin
            for (int s = 0; s < NS; s++) begin
                exp_idx_q.push_back(s);
            end
        end
        @(negedge clk);
        start      = 1'b0;
        reinit     = 1'b0;
        abort      = 1'b0;
        num_epochs = '0;
    endtask

    // Follows a run until done or the budget expires, popping the expected index on each update.
    task automatic monitorRun(input int budget, input int poke_a, input int poke_b,
                              output int done_cycle, output int trains, output int winits,
                              output int winit_first, output int busy_cycles, output int excl_err);
        int cyc;
        done_cycle  = -1;
        trains      = 0;
        winits      = 0;
        winit_first = -1;
        busy_cycles = 0;
        excl_err    = 0;
        cyc         = 1;
        while (cyc <= budget) begin
            if (training) begin
                trains++;
                checkOutput("update_valid", sample_valid, 1);
                if (exp_idx_q.size() == 0) begin
                    checkOutput("extra_update", 1, 0);
                end else begin
                    checkOutput("update_idx", sample_idx, exp_idx_q.pop_front());
                end
            end
            if (weight_init) begin
                winits++;
                if (winit_first < 0) winit_first = cyc;
            end
            if (busy) busy_cycles++;
            if ((int'(training) + int'(weight_init) + int'(done)) > 1) excl_err++;
            start      = (cyc == poke_a) || (cyc == poke_b);
            reinit     = start;
            num_epochs = start ? EW'(5) : '0;
            if (done) begin
                done_cycle = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start      = 1'b0;
        reinit     = 1'b0;
        num_epochs = '0;
    endtask

    initial begin
        int dc, tr, wi, wf, bc, ex, cnt_tr, cnt_done;

        // {reinit, abort_with_start, epochs, poke_a, poke_b, latency, trains, winits, final epoch}
        vecs[0] = '{1'b1, 1'b0, 3, 0, 0, 38, 12, 1, 3};
        vecs[1] = '{1'b0, 1'b0, 1, 0, 0, 13, 4, 0, 1};
        vecs[2] = '{1'b0, 1'b0, 0, 0, 0, 1, 0, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 1, 0, 0, 14, 4, 1, 1};
        vecs[4] = '{1'b0, 1'b0, 2, 5, 10, 25, 8, 0, 2};
        vecs[5] = '{1'b1, 1'b0, 7, 0, 0, 86, 28, 1, 7};
        vecs[6] = '{1'b0, 1'b0, 5, 0, 0, 61, 20, 0, 5};

        rst        = 1'b1;
        start      = 1'b0;
        reinit     = 1'b0;
        abort      = 1'b0;
        num_epochs = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {weight_init, sample_valid, training, busy, done}, 0);
        checkOutput("reset_epoch", epoch_count, 0);
        checkOutput("reset_idx", sample_idx, 0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            $display("[TB] run %0d: reinit=%0d epochs=%0d", v, vecs[v].reinit, vecs[v].epochs);
            exp_idx_q.delete();
            applyStimulus(vecs[v].reinit, vecs[v].abort_with_start, vecs[v].epochs);
            monitorRun(vecs[v].exp_latency + 10, vecs[v].poke_a, vecs[v].poke_b,
                       dc, tr, wi, wf, bc, ex);
            checkOutput("done_cycle", dc, vecs[v].exp_latency);
            checkOutput("train_pulses", tr, vecs[v].exp_trains);
            checkOutput("winit_pulses", wi, vecs[v].exp_winits);
            checkOutput("winit_cycle", wf, vecs[v].reinit ? 1 : -1);
            checkOutput("busy_cycles", bc, vecs[v].exp_latency);
            checkOutput("pulse_exclusive", ex, 0);
            checkOutput("updates_left", exp_idx_q.size(), 0);
            @(negedge clk);
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_done", done, 0);
            checkOutput("final_epoch", epoch_count, vecs[v].exp_final_epoch);
        end

        // Abort raised in the LOAD cycle leading into the second UPDATE.
        exp_idx_q.delete();
        applyStimulus(1'b0, 1'b0, 3);
        cnt_tr   = 0;
        cnt_done = 0;
        for (int c = 1; c <= 5; c++) begin
            if (training) cnt_tr++;
            if (done) cnt_done++;
            if (c == 5) begin
                checkOutput("abort_pre_load", {sample_valid, training}, 2'b10);
                abort = 1'b1;
            end
            @(negedge clk);
        end
        abort = 1'b0;
        checkOutput("abort_idle", {busy, sample_valid, training, done}, 0);
        for (int c = 0; c < 15; c++) begin
            if (training) cnt_tr++;
            if (done) cnt_done++;
            @(negedge clk);
        end
        checkOutput("abort_train_pulses", cnt_tr, 1);
        checkOutput("abort_no_done", cnt_done, 0);

        // Reset while loading the first sample of the second epoch.
        exp_idx_q.delete();
        applyStimulus(1'b0, 1'b0, 3);
        repeat (12) @(negedge clk);
        checkOutput("rst_pre_state", {sample_valid, training}, 2'b10);
        checkOutput("rst_pre_epoch", epoch_count, 1);
        checkOutput("rst_pre_idx", sample_idx, 0);
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_outputs", {weight_init, sample_valid, training, busy, done}, 0);
        checkOutput("rst_mid_epoch", epoch_count, 0);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        exp_idx_q.delete();
        applyStimulus(1'b0, 1'b0, 1);
        monitorRun(30, 0, 0, dc, tr, wi, wf, bc, ex);
        checkOutput("rst_rerun_done", dc, 13);
        checkOutput("rst_rerun_trains", tr, 4);
        checkOutput("rst_rerun_epoch", epoch_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
